// File: rtl/rt_pkg.sv
// Shared constants and state encoding for the reaction-timer self-test partner.
package rt_pkg;

  localparam int BCD_MAX        = 9999;
  localparam int PRESS_MS_DEF   = 20;
  localparam int TIMEOUT_MS_DEF = 5000;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_START = 5'b00010,
    S_WAIT  = 5'b00100,
    S_DELAY = 5'b01000,
    S_RESP  = 5'b10000
  } rt_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with ripple carry and hold at 9999.
module bcd_counter4 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic        sat,
  output logic [15:0] bcd
);

  logic [15:0] bcd_q, bcd_d;
  logic        carry;

  assign sat = (bcd_q == 16'h9999);
  assign bcd = bcd_q;

  always_comb begin
    bcd_d = bcd_q;
    carry = 1'b1;
    if (clr) begin
      bcd_d = 16'h0000;
    end else if (inc && !sat) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (bcd_q[4*i +: 4] == 4'd9) begin
            bcd_d[4*i +: 4] = 4'd0;
          end else begin
            bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) bcd_q <= 16'h0000;
    else       bcd_q <= bcd_d;
  end

endmodule

// File: rtl/rt_auto_subject.sv
// Emulated test subject: presses start, waits for the stimulus, holds off the
// programmed delay, presses response, and reports the applied delay in BCD.
module rt_auto_subject
  import rt_pkg::*;
#(
  parameter int PRESS_MS   = PRESS_MS_DEF,
  parameter int TIMEOUT_MS = TIMEOUT_MS_DEF,
  parameter int DELAY_W    = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1ms,
  input  logic               go,
  input  logic [DELAY_W-1:0] delay_ms,
  input  logic               stimulus,
  output logic               start_btn,
  output logic               response_btn,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [15:0]        expected_bcd
);

  localparam int CNT_W = max3($clog2(PRESS_MS + 1), $clog2(TIMEOUT_MS + 1), DELAY_W);
  localparam logic [CNT_W-1:0]   PRESS_LAST = CNT_W'(PRESS_MS - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(TIMEOUT_MS - 1);
  localparam logic [DELAY_W-1:0] DLY_MAX    = DELAY_W'(BCD_MAX);

  rt_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic               stim_prev_q;
  logic               start_q, start_d, resp_q, resp_d, busy_q, busy_d;
  logic               done_q, done_d, err_q, err_d;
  logic [15:0]        exp_q, exp_d;
  logic               bcd_clr, bcd_inc, bcd_sat;
  logic [15:0]        bcd_val;
  logic               stim_rise;

  assign stim_rise = stimulus && !stim_prev_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  bcd_counter4 u_bcd (
    .clk   (clk),
    .reset (reset),
    .clr   (bcd_clr),
    .inc   (bcd_inc),
    .sat   (bcd_sat),
    .bcd   (bcd_val)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    exp_d   = exp_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    bcd_clr = 1'b0;
    bcd_inc = 1'b0;
    case (state_q)
      S_IDLE: if (go) begin
        state_d = S_START;
        delay_d = (delay_ms > DLY_MAX) ? DLY_MAX : delay_ms;
        cnt_d   = '0;
        bcd_clr = 1'b1;
      end
      S_START: if (tick_1ms) begin
        if (cnt_q == PRESS_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      end
      S_WAIT: begin
        // A zero delay skips DELAY so the response lands one clock after the edge.
        if (stim_rise) begin
          cnt_d   = '0;
          state_d = (delay_q == '0) ? S_RESP : S_DELAY;
        end else if (tick_1ms) begin
          if (cnt_q == TMO_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else cnt_d = cnt_inc;
        end
      end
      S_DELAY: begin
        if (!stimulus) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (tick_1ms) begin
          cnt_d   = cnt_inc;
          bcd_inc = !bcd_sat;
          if (cnt_inc == CNT_W'(delay_q)) begin
            state_d = S_RESP;
            cnt_d   = '0;
          end
        end
      end
      S_RESP: if (tick_1ms) begin
        if (cnt_q == PRESS_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          exp_d   = bcd_val;
        end else cnt_d = cnt_inc;
      end
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_START);
    resp_d  = (state_d == S_RESP);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      delay_q     <= '0;
      stim_prev_q <= 1'b0;
      start_q     <= 1'b0;
      resp_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      exp_q       <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      delay_q     <= delay_d;
      stim_prev_q <= stimulus;
      start_q     <= start_d;
      resp_q      <= resp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      exp_q       <= exp_d;
    end
  end

  assign start_btn    = start_q;
  assign response_btn = resp_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_err  = err_q;
  assign expected_bcd = exp_q;

endmodule

// File: tb/tb_rt_auto_subject.sv
// Directed bench for rt_auto_subject; ms ticks every 4 clocks, TIMEOUT_MS=50
// so the normal run's stimulus arrives 30 ticks after start release.
module tb_rt_auto_subject;

  localparam int P_MS = 20;
  localparam int T_MS = 50;

  logic        clk = 1'b0;
  logic        reset, tick_1ms, go, stimulus;
  logic [13:0] delay_ms;
  logic        start_btn, response_btn, busy, done, timeout_err;
  logic [15:0] expected_bcd;

  int n_cmp = 0, n_bad = 0, ncyc = 0;
  int st_ticks, rs_ticks, n_done, n_err;
  bit rs_seen;

  rt_auto_subject #(.PRESS_MS(P_MS), .TIMEOUT_MS(T_MS), .DELAY_W(14)) dut (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .go(go), .delay_ms(delay_ms),
    .stimulus(stimulus), .start_btn(start_btn), .response_btn(response_btn),
    .busy(busy), .done(done), .timeout_err(timeout_err), .expected_bcd(expected_bcd)
  );

  always #5 clk = ~clk;

  // One clock: tally pre-edge button ticks, then sample just after the edge.
  task automatic cyc();
    if (start_btn && tick_1ms)    st_ticks++;
    if (response_btn && tick_1ms) rs_ticks++;
    @(posedge clk); #1;
    ncyc++;
    tick_1ms = (ncyc % 4 == 0);
    if (done)         n_done++;
    if (timeout_err)  n_err++;
    if (response_btn) rs_seen = 1'b1;
  endtask

  task automatic start_go(input logic [13:0] d);
    st_ticks = 0; rs_ticks = 0; n_done = 0; n_err = 0; rs_seen = 1'b0;
    delay_ms = d; go = 1'b1;
    cyc();
    go = 1'b0; delay_ms = '0;
  endtask

  task automatic wait_release();
    int g = 0;
    while (start_btn && g < 2000) begin cyc(); g++; end
  endtask

  task automatic idle_ticks(input int n);
    int k = 0;
    bit t;
    while (k < n) begin t = tick_1ms; cyc(); if (t) k++; end
  endtask

  task automatic edge_to_resp(output int k, output bit last_t, output int g);
    stimulus = 1'b1;
    cyc();
    k = 0; last_t = 1'b0; g = 0;
    while (!response_btn && g < 60000) begin
      last_t = tick_1ms; cyc(); g++;
      if (last_t) k++;
    end
  endtask

  task automatic resp_to_done();
    int g = 0;
    while (response_btn && g < 2000) begin cyc(); g++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; stimulus = 1'b0; tick_1ms = 1'b0; delay_ms = '0;
    st_ticks = 0; rs_ticks = 0; n_done = 0; n_err = 0; rs_seen = 1'b0;
    cyc(); cyc();
    n_cmp++; if (start_btn !== 1'b0)    begin n_bad++; $display("FAIL reset_start: got %b want 0", start_btn); end
    n_cmp++; if (response_btn !== 1'b0) begin n_bad++; $display("FAIL reset_resp: got %b want 0", response_btn); end
    n_cmp++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)         begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (timeout_err !== 1'b0)  begin n_bad++; $display("FAIL reset_err: got %b want 0", timeout_err); end
    n_cmp++; if (expected_bcd !== 16'h0) begin n_bad++; $display("FAIL reset_bcd: got %h want 0000", expected_bcd); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_normal();
    int k, g; bit lt;
    start_go(14'd250);
    n_cmp++; if (start_btn !== 1'b1) begin n_bad++; $display("FAIL norm_start_lat: got %b want 1", start_btn); end
    n_cmp++; if (busy !== 1'b1)      begin n_bad++; $display("FAIL norm_busy: got %b want 1", busy); end
    wait_release();
    n_cmp++; if (st_ticks != P_MS)   begin n_bad++; $display("FAIL norm_start_ticks: got %0d want %0d", st_ticks, P_MS); end
    idle_ticks(30);
    n_cmp++; if (n_err != 0 || rs_seen) begin n_bad++; $display("FAIL norm_wait: err %0d resp %b want 0 0", n_err, rs_seen); end
    edge_to_resp(k, lt, g);
    n_cmp++; if (k != 250 || !lt || response_btn !== 1'b1) begin n_bad++; $display("FAIL norm_delay: ticks %0d last %b resp %b want 250 1 1", k, lt, response_btn); end
    resp_to_done();
    n_cmp++; if (rs_ticks != P_MS)   begin n_bad++; $display("FAIL norm_resp_ticks: got %0d want %0d", rs_ticks, P_MS); end
    n_cmp++; if (done !== 1'b1)      begin n_bad++; $display("FAIL norm_done_edge: got %b want 1", done); end
    n_cmp++; if (expected_bcd !== 16'h0250) begin n_bad++; $display("FAIL norm_bcd: got %h want 0250", expected_bcd); end
    stimulus = 1'b0;
    cyc(); cyc();
    n_cmp++; if (n_done != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL norm_end: dones %0d busy %b want 1 0", n_done, busy); end
  endtask

  task automatic test_zero_delay();
    int k, g; bit lt;
    start_go(14'd0);
    wait_release();
    idle_ticks(2);
    edge_to_resp(k, lt, g);
    n_cmp++; if (g != 0 || response_btn !== 1'b1) begin n_bad++; $display("FAIL zero_lat: extra clks %0d resp %b want 0 1", g, response_btn); end
    resp_to_done();
    n_cmp++; if (done !== 1'b1 || rs_ticks != P_MS) begin n_bad++; $display("FAIL zero_done: done %b ticks %0d want 1 %0d", done, rs_ticks, P_MS); end
    n_cmp++; if (expected_bcd !== 16'h0000) begin n_bad++; $display("FAIL zero_bcd: got %h want 0000", expected_bcd); end
    stimulus = 1'b0;
    cyc();
  endtask

  task automatic test_saturate();
    int k, g; bit lt;
    start_go(14'd12000);
    wait_release();
    idle_ticks(2);
    edge_to_resp(k, lt, g);
    n_cmp++; if (k != 9999 || !lt) begin n_bad++; $display("FAIL sat_delay: ticks %0d last %b want 9999 1", k, lt); end
    resp_to_done();
    n_cmp++; if (expected_bcd !== 16'h9999) begin n_bad++; $display("FAIL sat_bcd: got %h want 9999", expected_bcd); end
    stimulus = 1'b0;
    cyc();
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL sat_dones: got %0d want 1", n_done); end
  endtask

  task automatic test_timeout();
    int k = 0, g = 0; bit t;
    start_go(14'd100);
    wait_release();
    while (!timeout_err && g < 2000) begin t = tick_1ms; cyc(); g++; if (t) k++; end
    n_cmp++; if (k != T_MS || timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_ticks: got %0d err %b want %0d 1", k, timeout_err, T_MS); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_busy: got %b want 0", busy); end
    cyc(); cyc();
    n_cmp++; if (n_err != 1 || rs_seen) begin n_bad++; $display("FAIL tmo_pulse: errs %0d resp %b want 1 0", n_err, rs_seen); end
  endtask

  task automatic test_stim_fall();
    start_go(14'd100);
    wait_release();
    idle_ticks(5);
    stimulus = 1'b1;
    cyc();
    idle_ticks(10);
    stimulus = 1'b0;
    cyc();
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL fall_err: got %b want 1", timeout_err); end
    n_cmp++; if (busy !== 1'b0 || rs_seen) begin n_bad++; $display("FAIL fall_state: busy %b resp %b want 0 0", busy, rs_seen); end
    n_cmp++; if (expected_bcd !== 16'h9999) begin n_bad++; $display("FAIL fall_bcd: got %h want 9999", expected_bcd); end
    cyc();
  endtask

  task automatic test_reset_mid();
    int k, g; bit lt;
    start_go(14'd40);
    wait_release();
    idle_ticks(2);
    edge_to_resp(k, lt, g);
    go = 1'b1;
    cyc();
    go = 1'b0;
    n_cmp++; if (response_btn !== 1'b1 || start_btn !== 1'b0) begin n_bad++; $display("FAIL busy_go: resp %b start %b want 1 0", response_btn, start_btn); end
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    n_cmp++; if (response_btn !== 1'b0 || start_btn !== 1'b0) begin n_bad++; $display("FAIL rst_btns: resp %b start %b want 0 0", response_btn, start_btn); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_flags: busy %b done %b want 0 0", busy, done); end
    n_cmp++; if (expected_bcd !== 16'h0) begin n_bad++; $display("FAIL rst_bcd: got %h want 0000", expected_bcd); end
    reset = 1'b0; stimulus = 1'b0;
    repeat (200) cyc();
    n_cmp++; if (n_done != 0 || rs_ticks > 1) begin n_bad++; $display("FAIL rst_after: dones %0d resp ticks %0d want 0 <=1", n_done, rs_ticks); end
    n_cmp++; if (start_btn !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle: start %b busy %b want 0 0", start_btn, busy); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_delay();
    test_saturate();
    test_timeout();
    test_stim_fall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
